// File: rtl/itch_pkg.sv
// Shared definitions for the ITCH / MoldUDP64 receive path:
// framer FSM states, default geometry and ITCH message-type codes.
package itch_pkg;

    localparam int HDR_BYTES_DEF   = 20;
    localparam int MAX_MSG_LEN_DEF = 50;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_DROP
    } framer_state_t;

    localparam logic [7:0] MSG_SYSTEM_EVENT = 8'h53;
    localparam logic [7:0] MSG_ADD_ORDER    = 8'h41;
    localparam logic [7:0] MSG_ADD_MPID     = 8'h46;
    localparam logic [7:0] MSG_EXECUTED     = 8'h45;
    localparam logic [7:0] MSG_EXEC_PRICE   = 8'h43;
    localparam logic [7:0] MSG_CANCEL       = 8'h58;
    localparam logic [7:0] MSG_DELETE       = 8'h44;
    localparam logic [7:0] MSG_REPLACE      = 8'h55;

endpackage

// File: rtl/itch_mold_framer.sv
// Strips the MoldUDP64 header and splits the packet into length-prefixed
// ITCH messages, forwarding each message byte one cycle after it arrives.
module itch_mold_framer
    import itch_pkg::*;
#(
    parameter int HDR_BYTES   = HDR_BYTES_DEF,
    parameter int MAX_MSG_LEN = MAX_MSG_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [7:0]  byte_out,
    output logic        valid_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic        abort_out,
    output logic [31:0] msg_count,
    output logic [15:0] err_count
);

    localparam logic [15:0] LP_HDR_LAST = 16'(HDR_BYTES - 1);
    localparam logic [15:0] LP_MAX_LEN  = 16'(MAX_MSG_LEN);

    framer_state_t r_state;
    framer_state_t w_next_state;

    logic [15:0] r_hdr_cnt;
    logic [15:0] r_len;
    logic [15:0] r_byte_cnt;
    logic [7:0]  r_byte_out;
    logic        r_valid_out;
    logic        r_sop_out;
    logic        r_eop_out;
    logic        r_abort_out;
    logic [31:0] r_msg_count;
    logic [15:0] r_err_count;

    logic [15:0] w_hdr_cnt_nx;
    logic [15:0] w_len_nx;
    logic [15:0] w_byte_cnt_nx;
    logic [15:0] w_len_full;
    logic        w_final;
    logic        w_emit;
    logic        w_sop;
    logic        w_eop;
    logic        w_abort;
    logic        w_msg_inc;
    logic        w_err_inc;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign w_len_full = {r_len[15:8], s_data};
    assign w_final    = (r_byte_cnt == (r_len - 16'd1));

    always_comb begin
        w_next_state  = r_state;
        w_hdr_cnt_nx  = r_hdr_cnt;
        w_len_nx      = r_len;
        w_byte_cnt_nx = r_byte_cnt;
        w_emit        = 1'b0;
        w_sop         = 1'b0;
        w_eop         = 1'b0;
        w_abort       = 1'b0;
        w_msg_inc     = 1'b0;
        w_err_inc     = 1'b0;

        if (s_valid) begin
            unique case (r_state)
                ST_HDR: begin
                    if (s_last) begin
                        w_err_inc    = 1'b1;
                        w_hdr_cnt_nx = '0;
                    end else if (r_hdr_cnt == LP_HDR_LAST) begin
                        w_hdr_cnt_nx = '0;
                        w_next_state = ST_LEN_HI;
                    end else begin
                        w_hdr_cnt_nx = r_hdr_cnt + 16'd1;
                    end
                end
                ST_LEN_HI: begin
                    w_len_nx     = {s_data, r_len[7:0]};
                    w_next_state = s_last ? ST_HDR : ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    w_len_nx      = w_len_full;
                    w_byte_cnt_nx = '0;
                    if (s_last) begin
                        w_err_inc    = 1'b1;
                        w_next_state = ST_HDR;
                    end else if (w_len_full == 16'd0) begin
                        w_next_state = ST_LEN_HI;
                    end else if (w_len_full > LP_MAX_LEN) begin
                        w_err_inc    = 1'b1;
                        w_next_state = ST_DROP;
                    end else begin
                        w_next_state = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_emit = 1'b1;
                    w_sop  = (r_byte_cnt == 16'd0);
                    if (w_final) begin
                        w_eop         = 1'b1;
                        w_msg_inc     = 1'b1;
                        w_byte_cnt_nx = '0;
                        w_next_state  = s_last ? ST_HDR : ST_LEN_HI;
                    end else if (s_last) begin
                        // truncated message: flag it on the byte we did get
                        w_abort       = 1'b1;
                        w_err_inc     = 1'b1;
                        w_byte_cnt_nx = '0;
                        w_next_state  = ST_HDR;
                    end else begin
                        w_byte_cnt_nx = r_byte_cnt + 16'd1;
                    end
                end
                ST_DROP: begin
                    if (w_final) begin
                        w_byte_cnt_nx = '0;
                        w_next_state  = s_last ? ST_HDR : ST_LEN_HI;
                    end else if (s_last) begin
                        w_err_inc     = 1'b1;
                        w_byte_cnt_nx = '0;
                        w_next_state  = ST_HDR;
                    end else begin
                        w_byte_cnt_nx = r_byte_cnt + 16'd1;
                    end
                end
                default: w_next_state = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_HDR;
            r_hdr_cnt   <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_byte_out  <= '0;
            r_valid_out <= 1'b0;
            r_sop_out   <= 1'b0;
            r_eop_out   <= 1'b0;
            r_abort_out <= 1'b0;
            r_msg_count <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_hdr_cnt   <= w_hdr_cnt_nx;
            r_len       <= w_len_nx;
            r_byte_cnt  <= w_byte_cnt_nx;
            r_valid_out <= w_emit;
            r_sop_out   <= w_sop;
            r_eop_out   <= w_eop;
            r_abort_out <= w_abort;
            if (w_emit) begin
                r_byte_out <= s_data;
            end
            if (w_msg_inc) begin
                r_msg_count <= sat_inc32(r_msg_count);
            end
            if (w_err_inc) begin
                r_err_count <= sat_inc16(r_err_count);
            end
        end
    end

    assign byte_out  = r_byte_out;
    assign valid_out = r_valid_out;
    assign sop_out   = r_sop_out;
    assign eop_out   = r_eop_out;
    assign abort_out = r_abort_out;
    assign msg_count = r_msg_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_itch_mold_framer.sv
// Directed scoreboard bench for itch_mold_framer: expected output bytes are
// queued as input is driven and checked when they emerge one cycle later.
module tb_itch_mold_framer;
    import itch_pkg::*;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic [7:0]  byte_out;
    logic        valid_out;
    logic        sop_out;
    logic        eop_out;
    logic        abort_out;
    logic [31:0] msg_count;
    logic [15:0] err_count;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       abort;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;
    int   exp_msg = 0;
    int   exp_err = 0;

    itch_mold_framer dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .byte_out  (byte_out),
        .valid_out (valid_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .abort_out (abort_out),
        .msg_count (msg_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            logic want_v;
            want_v = (sb.size() != 0);
            total++;
            assert (valid_out === want_v) else begin
                bad++;
                $error("FAIL valid_out got=%b want=%b", valid_out, want_v);
            end
            if (want_v) begin
                e = sb.pop_front();
                total++;
                assert ({byte_out, sop_out, eop_out, abort_out} ===
                        {e.d, e.sop, e.eop, e.abort}) else begin
                    bad++;
                    $error("FAIL out_byte got=%h/%b%b%b want=%h/%b%b%b",
                           byte_out, sop_out, eop_out, abort_out,
                           e.d, e.sop, e.eop, e.abort);
                end
            end else begin
                total++;
                assert ({sop_out, eop_out, abort_out} === 3'b000) else begin
                    bad++;
                    $error("FAIL idle_flags got=%b%b%b want=000",
                           sop_out, eop_out, abort_out);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_msg"}, msg_count, 32'(exp_msg));
        chk({tag, "_err"}, {16'd0, err_count}, 32'(exp_err));
    endtask

    task automatic drive(input logic [7:0] d, input logic last, input int gap,
                         input bit out, input bit sop, input bit eop,
                         input bit ab);
        exp_t e;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        if (out) begin
            e.d = d;
            e.sop = sop;
            e.eop = eop;
            e.abort = ab;
            sb.push_back(e);
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'hxx;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hdr();
        for (int i = 0; i < 20; i++) begin
            drive(8'(8'hA0 + i), 1'b0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic len_bytes(input int len, input int gap);
        logic [15:0] l;
        l = 16'(len);
        drive(l[15:8], 1'b0, gap, 0, 0, 0, 0);
        drive(l[7:0], 1'b0, gap, 0, 0, 0, 0);
    endtask

    task automatic msg(input int len, input logic [7:0] t, input int cut,
                       input bit last_end, input int gap);
        len_bytes(len, gap);
        for (int i = 1; i <= len; i++) begin
            logic [7:0] d;
            bit fin, is_cut;
            d = (i == 1) ? t : 8'(i - 1);
            fin = (i == len);
            is_cut = (cut == i);
            drive(d, is_cut || (fin && last_end), gap, 1, i == 1,
                  fin && !is_cut, is_cut);
            if (is_cut) break;
        end
    endtask

    task automatic drop(input int len, input int cut, input bit last_end);
        for (int i = 1; i <= len; i++) begin
            drive(8'(i), (cut == i) || (i == len && last_end), 0, 0, 0, 0, 0);
            if (cut == i) break;
        end
    endtask

    initial begin
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte", {24'd0, byte_out}, 32'd0);
        chk("rst_flags", {28'd0, valid_out, sop_out, eop_out, abort_out}, 32'd0);
        chk_counts("rst");
        rst = 1'b1;
        mon_en = 1;

        // single message, s_last on its final byte
        hdr();
        msg(9, MSG_DELETE, 0, 1, 0);
        exp_msg++;
        chk_counts("single");

        // two messages with 3-cycle gaps
        hdr();
        msg(9, MSG_DELETE, 0, 0, 3);
        msg(9, MSG_DELETE, 0, 1, 3);
        exp_msg += 2;
        chk_counts("gaps");

        // zero-length block then a message
        hdr();
        len_bytes(0, 0);
        msg(9, MSG_DELETE, 0, 1, 0);
        exp_msg++;
        chk_counts("zero_len");

        // oversize block dropped, following message forwarded
        hdr();
        len_bytes(64, 0);
        exp_err++;
        drop(64, 0, 0);
        msg(9, MSG_DELETE, 0, 1, 0);
        exp_msg++;
        chk_counts("oversize");

        // truncated message, then a normal packet
        hdr();
        msg(9, MSG_DELETE, 5, 0, 0);
        exp_err++;
        chk_counts("abort");
        hdr();
        msg(9, MSG_DELETE, 0, 1, 0);
        exp_msg++;
        chk_counts("after_abort");

        // length boundaries, then s_last in LEN_HI is clean
        hdr();
        msg(1, MSG_ADD_ORDER, 0, 0, 0);
        msg(50, MSG_ADD_ORDER, 0, 0, 0);
        len_bytes(51, 0);
        exp_err++;
        drop(51, 0, 0);
        drive(8'h00, 1'b1, 0, 0, 0, 0, 0);
        exp_msg += 2;
        chk_counts("bounds");

        // s_last in HDR and LEN_LO are errors
        for (int i = 0; i < 5; i++) begin
            drive(8'(i), i == 4, 0, 0, 0, 0, 0);
        end
        exp_err++;
        chk_counts("last_in_hdr");
        hdr();
        drive(8'h00, 1'b0, 0, 0, 0, 0, 0);
        drive(8'h09, 1'b1, 0, 0, 0, 0, 0);
        exp_err++;
        chk_counts("last_in_lenlo");

        // s_last early in DROP is an error; on the final drop byte it is not
        hdr();
        len_bytes(64, 0);
        drop(64, 10, 0);
        exp_err += 2;
        chk_counts("drop_early");
        hdr();
        len_bytes(60, 0);
        drop(60, 0, 1);
        exp_err++;
        chk_counts("drop_clean");
        hdr();
        msg(9, MSG_DELETE, 0, 1, 0);
        exp_msg++;
        chk_counts("after_drop");

        // reset on the 4th payload byte discards the message silently
        hdr();
        len_bytes(9, 0);
        drive(MSG_DELETE, 1'b0, 0, 1, 1, 0, 0);
        drive(8'h01, 1'b0, 0, 1, 0, 0, 0);
        drive(8'h02, 1'b0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        drive(8'h03, 1'b0, 0, 0, 0, 0, 0);
        chk("mid_rst_byte", {24'd0, byte_out}, 32'd0);
        chk("mid_rst_flags",
            {28'd0, valid_out, sop_out, eop_out, abort_out}, 32'd0);
        exp_msg = 0;
        exp_err = 0;
        chk_counts("mid_rst");
        rst = 1'b1;
        hdr();
        msg(9, MSG_DELETE, 0, 1, 0);
        exp_msg++;
        chk_counts("post_rst");

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/itch_mold_framer.md
ITCH_MOLD_FRAMER -- requirements
Module: itch_mold_framer

Interface
REQ-001 The block SHALL have parameter HDR_BYTES, default 20, meaning the MoldUDP64 header bytes skipped at the start of each packet.
REQ-002 The block SHALL have parameter MAX_MSG_LEN, default 50, meaning the largest message length forwarded; longer messages are dropped.
REQ-003 The block SHALL have port clk  in  1  the single clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port s_valid  in  1  an input payload byte is present this cycle.
REQ-006 The block SHALL have port s_data  in  8  the UDP payload byte.
REQ-007 The block SHALL have port s_last  in  1  qualified by s_valid; marks the last byte of the UDP packet.
REQ-008 The block SHALL have port byte_out  out  8  the message byte fed to the parser's byte_in.
REQ-009 The block SHALL have port valid_out  out  1  the message byte is valid; this feeds the parser's valid_in.
REQ-010 The block SHALL have port sop_out  out  1  asserted with the first byte (type byte) of each message.
REQ-011 The block SHALL have port eop_out  out  1  asserted with the last byte of each message.
REQ-012 The block SHALL have port abort_out  out  1  a one-cycle pulse marking that a message in flight was truncated.
REQ-013 The block SHALL have port msg_count  out  32  count of complete messages forwarded.
REQ-014 The block SHALL have port err_count  out  16  count of framing errors.

Function
REQ-015 The FSM SHALL have the states HDR, LEN_HI, LEN_LO, PAYLOAD and DROP; it SHALL advance only on cycles with s_valid=1 and hold otherwise, including across gaps of any length.
REQ-016 In HDR, a counter SHALL count HDR_BYTES bytes; the last header byte SHALL move the FSM to LEN_HI; no output SHALL be produced in HDR.
REQ-017 LEN_HI SHALL capture length[15:8]; LEN_LO SHALL capture length[7:0] (big-endian).
REQ-018 On leaving LEN_LO, the FSM SHALL go to LEN_HI when length=0 (no output, no error), to DROP when length>MAX_MSG_LEN (err_count+1), and to PAYLOAD otherwise.
REQ-019 In PAYLOAD, each byte SHALL be registered to byte_out with valid_out=1 exactly 1 cycle after input; output valids SHALL preserve input gaps.
REQ-020 sop_out SHALL assert with the first payload byte; eop_out SHALL assert with byte number length; for length=1, sop_out and eop_out SHALL coincide.
REQ-021 On the eop byte, msg_count SHALL increment in the same cycle that eop_out is asserted, and the FSM SHALL return to LEN_HI.
REQ-022 DROP SHALL consume length bytes with no output and then return to LEN_HI.
REQ-023 s_last coinciding with the final byte of a message or dropped block SHALL be clean: no error, next state HDR.
REQ-024 s_last in LEN_HI SHALL be clean (packet end between messages): next state HDR.
REQ-025 s_last in HDR or LEN_LO SHALL be an error: err_count+1, next state HDR.
REQ-026 s_last before the final byte in PAYLOAD SHALL cause the following: the last byte is emitted with valid_out=1, eop_out=0 and abort_out=1; err_count+1; msg_count unchanged; next state HDR.
REQ-027 s_last before the final byte in DROP SHALL increment err_count and set the next state to HDR.
REQ-028 msg_count and err_count SHALL saturate at all-ones and not wrap.
REQ-029 When one cycle both ends a message and starts an error (e.g. oversize length after an eop), each counter SHALL increment at most once per cycle, with correct totals over consecutive cycles.

Reset
REQ-030 When rst=0 at a clock edge: state=HDR, the header counter, length register and byte counter SHALL be 0, byte_out=0, valid_out/sop_out/eop_out/abort_out=0, msg_count=0, err_count=0.
REQ-031 Reset SHALL take priority over all inputs; reset mid-message SHALL discard the message silently (no abort_out, no count).
REQ-032 The first s_valid byte after reset deassertion SHALL be treated as header byte 0.

Structure
REQ-033 The FSM state enum, HDR_BYTES default and MAX_MSG_LEN default SHALL live in the shared package itch_pkg, alongside the message-type codes.
REQ-034 The block SHALL be a single module with no sub-modules; the saturating counter MAY be a local function.
REQ-035 The outputs SHALL connect directly to the parser's byte_in/valid_in; sop_out, eop_out and abort_out are for monitoring and future resynchronisation.

Verification
REQ-036 Scenario: 20 header bytes, then len 00 09, then 44 01..08 with s_last on 08 -> bytes 44..08 on byte_out 1 cycle later; sop on 44, eop on 08; msg_count=1; err_count=0.
REQ-037 Scenario: two messages (len 9 'D', len 9 'D') in one packet with 3-cycle s_valid gaps -> 18 output bytes with the same gaps; msg_count=2.
REQ-038 Scenario: len 00 00 then len 00 09 message -> the zero-length block produces no output; the second message is forwarded intact; err_count=0.
REQ-039 Scenario: len 00 40 (64 > 50) followed by 64 bytes, then len 9 'D' -> the 64 bytes are dropped; err_count=1; the 'D' message is forwarded; msg_count=1.
REQ-040 Scenario: len 00 09 with s_last on the 5th payload byte -> 5 bytes out, abort_out on the 5th, no eop; err_count=1; the next packet parses normally.
REQ-041 Scenario: rst=0 asserted on the 4th payload byte -> all outputs 0 the next cycle; the following packet's first byte is treated as header; counters are 0.
